// File: rtl/andornor_result_checker_pkg.sv
// rtl/andornor_result_checker_pkg.sv - shared types and constants for the AND/OR/NOR result checker
package andornor_result_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MSK_AND = 0;
  localparam int MSK_OR  = 1;
  localparam int MSK_NOR = 2;

  localparam int DEF_DW    = 32;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/andornor_result_checker_if.sv
// rtl/andornor_result_checker_if.sv - result beat handshake: operands plus the unit's three results
interface andornor_result_checker_if
  import andornor_result_checker_pkg::*;
#(
  parameter int DW = DEF_DW
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW:0]   s_and;
  logic [DW:0]   s_or;
  logic [DW:0]   s_nor;

  modport master (output in_valid, a, b, s_and, s_or, s_nor, input in_ready);
  modport slave  (input in_valid, a, b, s_and, s_or, s_nor, output in_ready);
endinterface

// File: rtl/andornor_expect.sv
// rtl/andornor_expect.sv - golden AND/OR/NOR results; the carry-out bit is always zero
module andornor_expect
  import andornor_result_checker_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW:0]   e_and,
  output logic [DW:0]   e_or,
  output logic [DW:0]   e_nor
);
  assign e_and = {1'b0, a & b};
  assign e_or  = {1'b0, a | b};
  assign e_nor = {1'b0, ~(a | b)};
endmodule

// File: rtl/andornor_result_checker.sv
// rtl/andornor_result_checker.sv - checker top: handshake, beat/mask pipe, statistics and run FSM
module andornor_result_checker
  import andornor_result_checker_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_vectors,
  andornor_result_checker_if.slave beat,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         vec_count,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         first_err_idx,
  output logic [2:0]               first_err_mask
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, acc_q, acc_d, vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d, idx_q, idx_d;
  logic [2:0]       fmask_q, fmask_d, mask_q, mask_d;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic [DW-1:0]    a_q, a_d, b_q, b_d;
  logic [DW:0]      sand_q, sand_d, sor_q, sor_d, snor_q, snor_d;
  logic [DW:0]      e_and, e_or, e_nor;
  logic             in_ready, xfer;

  andornor_expect #(.DW(DW)) u_expect (
    .a     (a_q),
    .b     (b_q),
    .e_and (e_and),
    .e_or  (e_or),
    .e_nor (e_nor)
  );

  assign in_ready      = (state_q == ST_RUN) && (acc_q < num_q);
  assign beat.in_ready = in_ready;
  assign xfer          = beat.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    err_d   = err_q;
    idx_d   = idx_q;
    fmask_d = fmask_q;
    a_d     = a_q;
    b_d     = b_q;
    sand_d  = sand_q;
    sor_d   = sor_q;
    snor_d  = snor_q;

    v0_d = xfer;
    if (xfer) begin
      a_d    = beat.a;
      b_d    = beat.b;
      sand_d = beat.s_and;
      sor_d  = beat.s_or;
      snor_d = beat.s_nor;
      acc_d  = acc_q + CNT_W'(1);
    end

    v1_d            = v0_q;
    mask_d          = '0;
    mask_d[MSK_AND] = (sand_q != e_and);
    mask_d[MSK_OR]  = (sor_q != e_or);
    mask_d[MSK_NOR] = (snor_q != e_nor);

    // Beats retire in order, so vec_q is the index of the vector being committed.
    if (v1_q) begin
      vec_d = vec_q + CNT_W'(1);
      if (mask_q != 3'b000) begin
        if (err_q == '0) begin
          idx_d   = vec_q;
          fmask_d = mask_q;
        end
        if (err_q != '1) err_d = err_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_RUN: if (vec_q == num_q) state_d = ST_DONE;
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_d   = num_vectors;
          acc_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          idx_d   = '0;
          fmask_d = '0;
          v0_d    = 1'b0;
          v1_d    = 1'b0;
          state_d = (num_vectors == '0) ? ST_DONE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      acc_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      fmask_q <= '0;
      mask_q  <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sand_q  <= '0;
      sor_q   <= '0;
      snor_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      fmask_q <= fmask_d;
      mask_q  <= mask_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sand_q  <= sand_d;
      sor_q   <= sor_d;
      snor_q  <= snor_d;
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (err_q == '0);
  assign vec_count      = vec_q;
  assign err_count      = err_q;
  assign first_err_idx  = idx_q;
  assign first_err_mask = fmask_q;
endmodule

// File: tb/tb_andornor_result_checker.sv
// tb/tb_andornor_result_checker.sv - directed bench for the AND/OR/NOR result checker
module tb_andornor_result_checker;
  localparam int DW    = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_count, err_count, first_err_idx;
  logic [2:0]       first_err_mask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  andornor_result_checker_if #(.DW(DW)) bif ();

  andornor_result_checker #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_vectors    (num_vectors),
    .beat           (bif),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .vec_count      (vec_count),
    .err_count      (err_count),
    .first_err_idx  (first_err_idx),
    .first_err_mask (first_err_mask)
  );

  // All tasks enter and leave on a falling edge.
  task automatic do_start(input logic [CNT_W-1:0] n);
    start = 1'b1;
    num_vectors = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW:0] sa, input logic [DW:0] so, input logic [DW:0] sn);
    int w;
    w = 0;
    bif.in_valid = 1'b1;
    bif.a = a;
    bif.b = b;
    bif.s_and = sa;
    bif.s_or = so;
    bif.s_nor = sn;
    while (!bif.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (bif.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: in_ready=%b after %0d clk, required 1", bif.in_ready, w);
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  task automatic send_good(input logic [DW-1:0] a, input logic [DW-1:0] b);
    send(a, b, {1'b0, a & b}, {1'b0, a | b}, {1'b0, ~(a | b)});
  endtask

  task automatic wait_done(input int budget);
    int w;
    w = 0;
    while (!done && w < budget) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: done=%b after %0d clk, required 1", done, w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, pass, bif.in_ready} !== 4'b0000 || vec_count !== 16'd0 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: busy/done/pass/rdy=%b vec=%0d err=%0d, required 0000 0 0",
               {busy, done, pass, bif.in_ready}, vec_count, err_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_good();
    do_start(16'd3);
    send_good(32'd19999, 32'd112345);
    send_good(32'd15, 32'd15);
    send_good(32'd11, 32'd10);
    tests++;
    if (bif.in_ready !== 1'b0 || vec_count !== 16'd1) begin
      fails++;
      $display("FAIL good_after_last: in_ready=%b vec=%0d, required 0 1", bif.in_ready, vec_count);
    end
    @(negedge clk);
    tests++;
    if (vec_count !== 16'd2) begin
      fails++;
      $display("FAIL good_latency1: vec=%0d, required 2", vec_count);
    end
    @(negedge clk);
    tests++;
    if (vec_count !== 16'd3 || done !== 1'b0) begin
      fails++;
      $display("FAIL good_latency2: vec=%0d done=%b, required 3 0", vec_count, done);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL good_done: done=%b pass=%b busy=%b err=%0d, required 1 1 0 0",
               done, pass, busy, err_count);
    end
  endtask

  task automatic test_or_mismatch();
    do_start(16'd2);
    send(32'd5, 32'd7, 33'h5, 33'h6, 33'h0_FFFF_FFF8);
    send_good(32'd9, 32'd3);
    wait_done(10);
    tests++;
    if (err_count !== 16'd1 || first_err_idx !== 16'd0 || first_err_mask !== 3'b010 ||
        vec_count !== 16'd2 || pass !== 1'b0) begin
      fails++;
      $display("FAIL or_mismatch: err=%0d idx=%0d mask=%b vec=%0d pass=%b, required 1 0 010 2 0",
               err_count, first_err_idx, first_err_mask, vec_count, pass);
    end
  endtask

  task automatic test_carry_bit();
    do_start(16'd4);
    send(32'd0, 32'd0, 33'h0, 33'h0, 33'h1_FFFF_FFFF);
    send_good(32'd1, 32'd2);
    send_good(32'hA5A5_0000, 32'h0F0F_F0F0);
    send(32'd8, 32'd12, 33'h9, 33'hC, 33'h0_FFFF_FFF3);
    wait_done(10);
    tests++;
    if (err_count !== 16'd2 || first_err_idx !== 16'd0 || first_err_mask !== 3'b100 ||
        vec_count !== 16'd4 || pass !== 1'b0) begin
      fails++;
      $display("FAIL carry_bit: err=%0d idx=%0d mask=%b vec=%0d pass=%b, required 2 0 100 4 0",
               err_count, first_err_idx, first_err_mask, vec_count, pass);
    end
  endtask

  task automatic test_flow_control();
    int accepts;
    accepts = 0;
    do_start(16'd2);
    bif.in_valid = 1'b1;
    bif.a = 32'd3;
    bif.b = 32'd5;
    bif.s_and = 33'h1;
    bif.s_or = 33'h7;
    bif.s_nor = 33'h0_FFFF_FFF8;
    for (int i = 0; i < 5; i++) begin
      if (bif.in_ready) accepts++;
      @(negedge clk);
    end
    tests++;
    if (accepts != 2 || bif.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL hold_valid: accepts=%0d in_ready=%b, required 2 0", accepts, bif.in_ready);
    end
    bif.in_valid = 1'b0;
    wait_done(10);
    tests++;
    if (vec_count !== 16'd2 || pass !== 1'b1) begin
      fails++;
      $display("FAIL hold_valid_end: vec=%0d pass=%b, required 2 1", vec_count, pass);
    end

    do_start(16'd3);
    send_good(32'hFFFF_0000, 32'h00FF_00FF);
    repeat (3) @(negedge clk);
    do_start(16'd7);
    tests++;
    if (vec_count !== 16'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL valid_gap: vec=%0d busy=%b, required 1 1", vec_count, busy);
    end
    send_good(32'd0, 32'hFFFF_FFFF);
    send_good(32'h1234_5678, 32'h8765_4321);
    wait_done(10);
    tests++;
    if (vec_count !== 16'd3 || pass !== 1'b1) begin
      fails++;
      $display("FAIL start_in_run: vec=%0d pass=%b, required 3 1", vec_count, pass);
    end
  endtask

  task automatic test_zero_vectors();
    logic saw_ready;
    saw_ready = 1'b0;
    do_start(16'd0);
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 16'd0) begin
      fails++;
      $display("FAIL zero_done: done=%b pass=%b vec=%0d, required 1 1 0", done, pass, vec_count);
    end
    bif.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bif.in_ready) saw_ready = 1'b1;
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    tests++;
    if (saw_ready !== 1'b0 || vec_count !== 16'd0) begin
      fails++;
      $display("FAIL zero_ready: saw_ready=%b vec=%0d, required 0 0", saw_ready, vec_count);
    end
  endtask

  task automatic test_async_reset();
    do_start(16'd4);
    send(32'd5, 32'd7, 33'h5, 33'h6, 33'h0_FFFF_FFF8);
    send_good(32'd6, 32'd3);
    repeat (2) @(negedge clk);
    tests++;
    if (vec_count !== 16'd2 || err_count !== 16'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: vec=%0d err=%0d busy=%b, required 2 1 1", vec_count, err_count, busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, pass, bif.in_ready} !== 4'b0000 || vec_count !== 16'd0 ||
        err_count !== 16'd0 || first_err_mask !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: busy/done/pass/rdy=%b vec=%0d err=%0d mask=%b, required 0000 0 0 000",
               {busy, done, pass, bif.in_ready}, vec_count, err_count, first_err_mask);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(16'd2);
    send_good(32'd100, 32'd200);
    send_good(32'h8000_0001, 32'h7FFF_FFFE);
    wait_done(10);
    tests++;
    if (vec_count !== 16'd2 || err_count !== 16'd0 || pass !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_run: vec=%0d err=%0d pass=%b, required 2 0 1", vec_count, err_count, pass);
    end
  endtask

  initial begin
    bif.in_valid = 1'b0;
    bif.a = '0;
    bif.b = '0;
    bif.s_and = '0;
    bif.s_or = '0;
    bif.s_nor = '0;
    @(negedge clk);
    test_reset();
    test_all_good();
    test_or_mismatch();
    test_carry_bit();
    test_flow_control();
    test_zero_vectors();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
